// File: rtl/audioout_rdma.sv
// Read-DMA engine: fetches 16-beat INCR bursts over an AXI read channel into a sample FIFO.
// Optional read-ID checking is enabled by defining AUDIOOUT_RDMA_RID_CHECK_EN.
module audioout_rdma #(
    parameter int         FIFO_DEPTH = 32,
    parameter logic [5:0] AXI_ID     = 6'h01
) (
    input  logic        gclk,
    input  logic        greset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic [5:0]  aid_audioout,
    output logic [31:0] axi_addr_audioout,
    output logic        avalid_audioout,
    output logic        awrite_audioout,
    input  logic        aready_audioout,
    output logic [3:0]  alen_audioout,
    output logic [1:0]  asize_audioout,
    output logic [1:0]  aburst_audioout,
    input  logic [5:0]  rid_audioout,
    input  logic [63:0] rdata_audioout,
    input  logic        rlast_audioout,
    input  logic        rvalid_audioout,
    output logic        rready_audioout,
    output logic [63:0] smp_data,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        rid_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] BURST_C = (PTR_W+1)'(16);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_SPACE = 3'd1;
    localparam logic [2:0] ST_ADDR       = 3'd2;
    localparam logic [2:0] ST_DATA       = 3'd3;
    localparam logic [2:0] ST_DRAIN      = 3'd4;

    logic [2:0]  state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [15:0] remaining_reg, remaining_next;
    logic        done_reg, done_next;

    // FIFO = one registered head slot plus a RAM for the entries behind it.
    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   mem_count_reg;
    logic             head_valid_reg;
    logic [63:0]      head_reg;

    logic [PTR_W:0] count;
    logic           full;
    logic           space_ok;
    logic           push, pop, head_load, mem_rd, mem_wr, bypass;

    assign aid_audioout    = AXI_ID;
    assign awrite_audioout = 1'b0;
    assign alen_audioout   = 4'hF;
    assign asize_audioout  = 2'b11;
    assign aburst_audioout = 2'b01;

    assign busy              = (state_reg != ST_IDLE);
    assign done              = done_reg;
    assign axi_addr_audioout = addr_reg;
    assign avalid_audioout   = (state_reg == ST_ADDR);
    assign rready_audioout   = (state_reg == ST_DATA) && !full;
    assign smp_valid         = head_valid_reg;
    assign smp_data          = head_reg;

    assign count    = mem_count_reg + {{PTR_W{1'b0}}, head_valid_reg};
    assign full     = (count == DEPTH_C);
    assign space_ok = (count <= (DEPTH_C - BURST_C));

    assign push      = rvalid_audioout && rready_audioout;
    assign pop       = head_valid_reg && smp_ready;
    assign head_load = !head_valid_reg || pop;
    assign mem_rd    = head_load && (mem_count_reg != '0);
    // An empty FIFO takes the incoming beat straight into the head slot.
    assign bypass    = head_load && (mem_count_reg == '0) && push;
    assign mem_wr    = push && !bypass;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (num_bursts != 16'd0) begin
                        addr_next      = {base_addr[31:7], 7'b0};
                        remaining_next = num_bursts;
                        state_next     = ST_WAIT_SPACE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (space_ok) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (aready_audioout) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (push && rlast_audioout) begin
                    addr_next      = addr_reg + 32'd128;
                    remaining_next = remaining_reg - 16'd1;
                    state_next     = (remaining_reg == 16'd1) ? ST_DRAIN : ST_WAIT_SPACE;
                end
            end
            ST_DRAIN: begin
                if (count == '0) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (greset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 32'd0;
            remaining_reg <= 16'd0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
        end
    end

    always_ff @(posedge gclk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= rdata_audioout;
        end
    end

    always_ff @(posedge gclk) begin
        if (greset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_count_reg  <= '0;
            head_valid_reg <= 1'b0;
            head_reg       <= 64'd0;
        end else begin
            if (mem_rd) begin
                head_reg       <= mem[rd_ptr_reg];
                head_valid_reg <= 1'b1;
                rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
            end else if (bypass) begin
                head_reg       <= rdata_audioout;
                head_valid_reg <= 1'b1;
            end else if (head_load) begin
                head_valid_reg <= 1'b0;
            end
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            case ({mem_wr, mem_rd})
                2'b10:   mem_count_reg <= mem_count_reg + (PTR_W+1)'(1);
                2'b01:   mem_count_reg <= mem_count_reg - (PTR_W+1)'(1);
                default: mem_count_reg <= mem_count_reg;
            endcase
        end
    end

`ifdef AUDIOOUT_RDMA_RID_CHECK_EN
    logic rid_err_reg;

    // Mismatching beats are still stored; the flag only reports the fault.
    always_ff @(posedge gclk) begin
        if (greset) begin
            rid_err_reg <= 1'b0;
        end else if (push && (rid_audioout != AXI_ID)) begin
            rid_err_reg <= 1'b1;
        end
    end

    assign rid_err = rid_err_reg;
`else
    logic unused_rid;

    assign unused_rid = ^rid_audioout;
    assign rid_err    = 1'b0;
`endif

endmodule

// File: tb/tb_audioout_rdma.sv
// Self-checking bench for audioout_rdma: AXI read slave model, sample consumer and a
// data scoreboard, driven by a transfer table plus hand-written corner sequences.
module tb_audioout_rdma;

    localparam logic [5:0] ID = 6'h01;
`ifdef AUDIOOUT_RDMA_RID_CHECK_EN
    localparam logic RID_EXP = 1'b1;
`else
    localparam logic RID_EXP = 1'b0;
`endif

    logic        gclk = 1'b0;
    logic        greset, start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy, done;
    logic [5:0]  aid_audioout;
    logic [31:0] axi_addr_audioout;
    logic        avalid_audioout, awrite_audioout, aready_audioout;
    logic [3:0]  alen_audioout;
    logic [1:0]  asize_audioout, aburst_audioout;
    logic [5:0]  rid_audioout;
    logic [63:0] rdata_audioout;
    logic        rlast_audioout, rvalid_audioout, rready_audioout;
    logic [63:0] smp_data;
    logic        smp_valid, smp_ready, rid_err;

    audioout_rdma #(.FIFO_DEPTH(32), .AXI_ID(ID)) dut (
        .gclk(gclk), .greset(greset), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done),
        .aid_audioout(aid_audioout), .axi_addr_audioout(axi_addr_audioout),
        .avalid_audioout(avalid_audioout), .awrite_audioout(awrite_audioout),
        .aready_audioout(aready_audioout), .alen_audioout(alen_audioout),
        .asize_audioout(asize_audioout), .aburst_audioout(aburst_audioout),
        .rid_audioout(rid_audioout), .rdata_audioout(rdata_audioout),
        .rlast_audioout(rlast_audioout), .rvalid_audioout(rvalid_audioout),
        .rready_audioout(rready_audioout), .smp_data(smp_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .rid_err(rid_err)
    );

    always #5 gclk = ~gclk;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          pop_at_hs[$];
    int          data_ctr = 0;
    int          pop_cnt = 0;
    int          beats_left = 0;
    int          ar_wait_cnt = 0;
    int          addr_unstable = 0;
    int          avalid_drop = 0;
    logic [31:0] stall_addr = 32'd0;
    int          ar_stall = 0;
    int          smp_mode = 0;
    int          extra_beats = 0;
    int          long_burst_at = -1;

    typedef struct {
        logic [31:0] base;
        logic [15:0] nb;
        int          stall;
        int          mode;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // AXI slave + consumer + scoreboard. Inputs change on the falling edge;
    // handshakes are decided just after, since no DUT output depends on them combinationally.
    initial begin
        aready_audioout = 1'b0;
        rvalid_audioout = 1'b0;
        rlast_audioout  = 1'b0;
        rdata_audioout  = 64'd0;
        rid_audioout    = ID;
        smp_ready       = 1'b0;
        forever begin
            @(negedge gclk);
            rvalid_audioout = (beats_left > 0);
            rdata_audioout  = 64'(data_ctr);
            rlast_audioout  = (beats_left == 1);
            rid_audioout    = ((data_ctr % 16) == 5) ? 6'h02 : ID;
            aready_audioout = (ar_wait_cnt >= ar_stall);
            case (smp_mode)
                0:       smp_ready = 1'b1;
                1:       smp_ready = 1'($urandom_range(0, 1));
                default: smp_ready = 1'b0;
            endcase
            #1;
            if (greset) begin
                beats_left  = 0;
                ar_wait_cnt = 0;
                exp_q.delete();
            end else begin
                if (rvalid_audioout && rready_audioout) begin
                    exp_q.push_back(rdata_audioout);
                    data_ctr++;
                    beats_left--;
                end
                if (avalid_audioout) begin
                    if (ar_wait_cnt > 0 && axi_addr_audioout != stall_addr) addr_unstable++;
                    if (aready_audioout) begin
                        pop_at_hs.push_back(pop_cnt);
                        addr_q.push_back(axi_addr_audioout);
                        beats_left  = 16 + ((addr_q.size() - 1 == long_burst_at) ? extra_beats : 0);
                        ar_wait_cnt = 0;
                    end else begin
                        if (ar_wait_cnt == 0) stall_addr = axi_addr_audioout;
                        ar_wait_cnt++;
                    end
                end else if (ar_wait_cnt > 0) begin
                    avalid_drop++;
                    ar_wait_cnt = 0;
                end
                if (smp_valid && smp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sample_unexpected: got %0h required no sample", smp_data);
                    end else begin
                        chk("sample", smp_data, exp_q.pop_front());
                    end
                    pop_cnt++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(negedge gclk); #2;
        start = 1'b1; base_addr = b; num_bursts = n;
        @(negedge gclk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int cyc = 0;
        int pulses = 0;
        while (pulses == 0 && cyc < bound) begin
            @(negedge gclk); #2;
            if (done) begin
                pulses++;
                chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
                chk({name, "_fifo_empty_at_done"}, 64'(exp_q.size()), 64'(0));
            end
            cyc++;
        end
        repeat (4) begin
            @(negedge gclk); #2;
            if (done) pulses++;
        end
        chk({name, "_done_pulses"}, 64'(pulses), 64'(1));
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int a0 = addr_q.size();
        int p0 = pop_cnt;
        int nb = int'(v.nb);
        int dpulses = 0;
        ar_stall = v.stall;
        smp_mode = v.mode;
        pulse_start(v.base, v.nb);
        if (nb == 0) begin
            chk("zero_done", 64'(done), 64'(1));
            chk("zero_busy", 64'(busy), 64'(0));
            repeat (4) begin
                @(negedge gclk); #2;
                if (done) dpulses++;
                if (avalid_audioout) dpulses += 100;
            end
            chk("zero_quiet_after", 64'(dpulses), 64'(0));
        end else begin
            chk("busy_after_start", 64'(busy), 64'(1));
            repeat (10) @(negedge gclk);
            #2;
            start = 1'b1; base_addr = 32'h5555_0000; num_bursts = 16'd7;
            @(negedge gclk); #2;
            start = 1'b0;
            wait_done(6000, "xfer");
            chk("burst_count", 64'(addr_q.size() - a0), 64'(nb));
            if (addr_q.size() - a0 >= nb) begin
                chk("first_addr", 64'(addr_q[a0]), 64'(v.first));
                chk("last_addr", 64'(addr_q[a0 + nb - 1]), 64'(v.last));
            end
            chk("sample_count", 64'(pop_cnt - p0), 64'(16 * nb));
            chk("addr_stable", 64'(addr_unstable), 64'(0));
            chk("avalid_no_drop", 64'(avalid_drop), 64'(0));
        end
        $display("xfer %0d: base=%08h bursts=%0d stall=%0d mode=%0d pops=%0d", idx, v.base, nb,
                 v.stall, v.mode, pop_cnt - p0);
    endtask

    initial begin
        int a0, p0, d0, cyc, hs3, dpulses;
        vecs[0] = '{32'h1000_0040, 16'd2, 0, 0, 32'h1000_0000, 32'h1000_0080};
        vecs[1] = '{32'hFFFF_FF80, 16'd2, 0, 0, 32'hFFFF_FF80, 32'h0000_0000};
        vecs[2] = '{32'h2000_007F, 16'd3, 5, 1, 32'h2000_0000, 32'h2000_0100};
        vecs[3] = '{32'h0000_0100, 16'd4, 1, 1, 32'h0000_0100, 32'h0000_0280};
        vecs[4] = '{32'h1234_5678, 16'd0, 0, 0, 32'h0, 32'h0};

        greset = 1'b1; start = 1'b0; base_addr = 32'd0; num_bursts = 16'd0;
        repeat (3) @(negedge gclk);
        #2;
        chk("rst_avalid", 64'(avalid_audioout), 64'(0));
        chk("rst_rready", 64'(rready_audioout), 64'(0));
        chk("rst_smp_valid", 64'(smp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rid_err", 64'(rid_err), 64'(0));
        chk("rst_axi_addr", 64'(axi_addr_audioout), 64'(0));
        chk("rst_smp_data", smp_data, 64'(0));
        chk("const_aid", 64'(aid_audioout), 64'(ID));
        chk("const_awrite", 64'(awrite_audioout), 64'(0));
        chk("const_alen", 64'(alen_audioout), 64'(4'hF));
        chk("const_asize", 64'(asize_audioout), 64'(2'b11));
        chk("const_aburst", 64'(aburst_audioout), 64'(2'b01));
        greset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], i);
            if (i == 0) chk("rid_err_after_bad_id", 64'(rid_err), 64'(RID_EXP));
        end

        // Consumer stalled: the third burst must wait for 16 pops.
        a0 = addr_q.size(); p0 = pop_cnt; ar_stall = 0; smp_mode = 2;
        pulse_start(32'h3000_0000, 16'd3);
        cyc = 0;
        while ((addr_q.size() - a0 < 2 || exp_q.size() < 32) && cyc < 500) begin
            @(negedge gclk); cyc++;
        end
        repeat (20) @(negedge gclk);
        #2;
        chk("hold_two_bursts", 64'(addr_q.size() - a0), 64'(2));
        chk("hold_fifo_level", 64'(exp_q.size()), 64'(32));
        chk("hold_avalid_low", 64'(avalid_audioout), 64'(0));
        chk("hold_smp_valid", 64'(smp_valid), 64'(1));
        smp_mode = 0;
        wait_done(2000, "hold");
        hs3 = (pop_at_hs.size() > a0 + 2) ? pop_at_hs[a0 + 2] - p0 : -1;
        chk("third_after_16_pops", 64'(hs3 >= 16), 64'(1));
        chk("hold_pops", 64'(pop_cnt - p0), 64'(48));
        $display("xfer hold: bursts=%0d pops=%0d third_issued_after=%0d", addr_q.size() - a0,
                 pop_cnt - p0, hs3);

        // Over-long second burst fills the FIFO: rready must drop and beats wait.
        a0 = addr_q.size(); p0 = pop_cnt; smp_mode = 2;
        long_burst_at = a0 + 1; extra_beats = 2;
        pulse_start(32'h4000_0000, 16'd2);
        cyc = 0;
        while (exp_q.size() < 32 && cyc < 500) begin
            @(negedge gclk); cyc++;
        end
        repeat (3) @(negedge gclk);
        #2;
        chk("full_rready_low", 64'(rready_audioout), 64'(0));
        chk("full_rvalid_held", 64'(rvalid_audioout), 64'(1));
        chk("full_no_extra_beat", 64'(exp_q.size()), 64'(32));
        smp_mode = 0;
        wait_done(2000, "full");
        chk("full_pops", 64'(pop_cnt - p0), 64'(34));
        long_burst_at = -1; extra_beats = 0;
        $display("xfer full: pops=%0d", pop_cnt - p0);

        // Reset during beat 7 of the first burst.
        d0 = data_ctr; smp_mode = 0;
        pulse_start(32'h5000_0000, 16'd2);
        cyc = 0;
        while (data_ctr - d0 < 7 && cyc < 300) begin
            @(negedge gclk); #2; cyc++;
        end
        greset = 1'b1;
        @(negedge gclk); #2;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_smp_valid", 64'(smp_valid), 64'(0));
        chk("abort_avalid", 64'(avalid_audioout), 64'(0));
        chk("abort_rready", 64'(rready_audioout), 64'(0));
        chk("abort_rid_err", 64'(rid_err), 64'(0));
        greset = 1'b0;
        dpulses = 0;
        repeat (6) begin
            @(negedge gclk); #2;
            if (done || busy || smp_valid) dpulses++;
        end
        chk("abort_quiet", 64'(dpulses), 64'(0));
        chk("abort_q_empty", 64'(exp_q.size()), 64'(0));
        $display("xfer abort: beats_before_reset=%0d", data_ctr - d0);

        run_xfer(vecs[0], 5);
        run_xfer(vecs[4], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
